// File: rtl/pipe_reg_elastic.sv
// Elastic register pipeline: DEPTH valid-tagged stages with collapsing bubbles,
// backpressure, synchronous flush and a registered occupancy count.
module pipe_reg_elastic #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy
);

  // Handshake: a beat moves when valid & ready are both high at the rising edge;
  // valid never depends on ready, ready may depend on valid further downstream.

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  logic [DEPTH-1:0] en;
  logic             en_acc;
  logic             in_fire;
  logic             out_fire;

  // A stage may advance if it is empty or anything below it can move.
  always_comb begin
    en_acc = out_ready;
    en     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      en_acc = en_acc | ~v_q[k];
      en[k]  = en_acc;
    end
  end

  assign in_ready = en[0] & ~flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = v_q[DEPTH-1] & out_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (en[0]) begin
        v_d[0] = in_valid;
        if (in_valid) d_d[0] = in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (en[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) d_d[k] = d_q[k-1];
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) occ_d = '0;
    else       occ_d = occ_q + CW'(in_fire) - CW'(out_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= RST_VAL;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed vector table plus hand-written latency, streaming, reset and
// randomized scoreboard sequences for pipe_reg_elastic.
module tb_pipe_reg_elastic;
  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 4;
  localparam int         CW      = 3;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] occupancy;

  pipe_reg_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // driver: inputs at negedge, in_ready checked before the edge, registers after
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.din;
    out_ready = v.ordy;
    flush     = v.fl;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'(v.e_ir));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_out_valid", idx), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("vec%0d_out_data", idx), 32'(out_data), 32'(v.e_od));
    chk($sformatf("vec%0d_occupancy", idx), 32'(occupancy), 32'(v.e_occ));
  endtask

  initial begin
    logic       exp_ir;
    logic [7:0] seq;
    int         acc;
    int         outs;

    // backpressure, bubble collapse, drain, flush and post-flush latency
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd1};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd2};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd2};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
    tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3};
    tbl[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4};
    tbl[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
    tbl[7]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'd4};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 3'd4};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd3};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 3'd2};
    tbl[11] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 3'd3};
    tbl[12] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 3'd0};
    tbl[13] = '{1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 3'd1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 3'd1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 3'd1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88, 3'd1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h88, 3'd0};

    // reset asserted between edges, checked without a clock edge
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(RST_VAL));
    chk("rst_occupancy", 32'(occupancy), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) apply_vec(tbl[i], i);

    // latency: one beat, valid for exactly one cycle after edge 3
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1; flush = 1'b0;
    #1 chk("lat_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("lat_out_valid_e%0d", e), 32'(out_valid), 32'(e == 3));
      if (e == 3) chk("lat_out_data", 32'(out_data), 32'(8'h3C));
    end

    // streaming: 100 beats, then drain
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      in_valid  = (c < 100);
      in_data   = 8'(c);
      out_ready = 1'b1;
      #1 chk($sformatf("stream_in_ready_c%0d", c), 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      acc  = (c + 1 < 100) ? c + 1 : 100;
      outs = (c < 3) ? 0 : ((c - 3 > 100) ? 100 : c - 3);
      chk($sformatf("stream_occ_c%0d", c), 32'(occupancy), 32'(acc - outs));
      chk($sformatf("stream_ov_c%0d", c), 32'(out_valid), 32'(c >= 3 && c <= 102));
      if (c >= 3 && c <= 102)
        chk($sformatf("stream_od_c%0d", c), 32'(out_data), 32'(c - 3));
    end

    // reset mid-stream with data held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(5 + i); out_ready = 1'b0;
      @(posedge clk);
    end
    #1 chk("mid_pre_occ", 32'(occupancy), 32'(3));
    #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_out_data", 32'(out_data), 32'(RST_VAL));
    chk("mid_rst_occupancy", 32'(occupancy), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against a FIFO scoreboard
    seq = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = seq;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ir = out_ready | (exp_q.size() < DEPTH);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
      if (exp_q.size() == 0) begin
        chk("rnd_empty_out_valid", 32'(out_valid), 32'(0));
      end else if (out_valid && out_ready) begin
        chk("rnd_out_data", 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_ir) begin
        exp_q.push_back(in_data);
        seq = seq + 8'd1;
      end
      @(posedge clk);
      #1;
      chk("rnd_occupancy", 32'(occupancy), 32'(exp_q.size()));
    end

    // bounded drain
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        chk("drain_out_data", 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      @(posedge clk);
    end
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'(0));
    chk("drain_out_valid", 32'(out_valid), 32'(0));
    chk("drain_occupancy", 32'(occupancy), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
